forward_scoreboard: RTL and testbench
=====================================

FORWARD_SCOREBOARD -- requirements
Module: forward_scoreboard

Interface
REQ-001 Parameter REG_W, default 5, register address width in bits.
REQ-002 Parameter NUM_SRC, default 2, number of source operands checked per issuing instruction.
REQ-003 Parameter DEPTH, default 3, number of tracked in-flight stages after issue: 1=EX, 2=MEM, 3=WB.
REQ-004 Parameter LOAD_READY, default 2, lowest stage index whose load result can be forwarded.
REQ-005 Parameter CNT_W, default 16, stall counter width.
REQ-006 The block SHALL use one clock; reset SHALL be synchronous and active-high.
REQ-007 clk  input  1  clock; all state updates on its rising edge.
REQ-008 rst  input  1  synchronous active-high reset.
REQ-009 issue_valid  input  1  an instruction in ID requests issue this cycle.
REQ-010 issue_regwrite  input  1  the issuing instruction writes a register.
REQ-011 issue_is_load  input  1  the issuing instruction is a load.
REQ-012 issue_rd  input  REG_W  destination register of the issuing instruction.
REQ-013 src_addr  input  NUM_SRC*REG_W  source register addresses; operand i occupies bits [i*REG_W +: REG_W].
REQ-014 flush  input  1  kill the instruction in stage 1 and the current issue.
REQ-015 fwd_sel  output  NUM_SRC*SEL_W  per-operand forward select, where SEL_W = clog2(DEPTH+1); 0 = register file, k = stage k.
REQ-016 stall  output  1  hold ID and insert a bubble.
REQ-017 stall_count  output  CNT_W  saturating count of stall cycles.

Function
REQ-018 Each stage entry SHALL hold valid, regwrite, is_load and rd.
REQ-019 Every cycle, entry k SHALL move to entry k+1 and entry DEPTH SHALL retire.
REQ-020 Entry 1 SHALL load the issue fields when issue_valid && !stall && !flush; otherwise it SHALL load a bubble (valid=0).
REQ-021 Stage k SHALL match operand i iff valid && regwrite && rd != 0 && rd == src_i.
REQ-022 fwd_sel for operand i SHALL be the lowest matching k (youngest producer wins), or 0 if no stage matches.
REQ-023 fwd_sel and stall SHALL be combinational from the stage state and the current inputs, with zero latency.
REQ-024 stall SHALL be 1 iff issue_valid && !flush, and for some operand the selected stage k < LOAD_READY and that entry's is_load = 1.
REQ-025 Under stall, fwd_sel SHALL still show the selected stage; the consumer ignores it.
REQ-026 A load-use hazard SHALL produce exactly LOAD_READY-1 stall cycles when the consumer issues directly behind the load (1 cycle at default).
REQ-027 On flush, the entry advancing out of stage 1 SHALL become a bubble in stage 2, and no new issue SHALL be captured; stages 2 and above are unaffected.
REQ-028 Simultaneous flush and stall condition: flush SHALL win, and stall SHALL be 0.
REQ-029 stall_count SHALL increment by 1 on every cycle with stall=1 and SHALL saturate at all-ones (no wrap).
REQ-030 Two operands with the same address SHALL receive identical fwd_sel.

Reset
REQ-031 On rst=1 at a clock edge, all entries SHALL become invalid and stall_count SHALL become 0.
REQ-032 Immediately after reset, fwd_sel SHALL be all 0 and stall SHALL be 0 for any inputs.
REQ-033 Reset SHALL take priority over flush and issue in the same cycle; an in-flight load is discarded, with no residual stall.

Structure
REQ-034 A shared package SHALL hold SEL_W computation, the stage-entry struct (valid, regwrite, is_load, rd), and the select encoding constants (SEL_RF=0).
REQ-035 One sub-module, fwd_match, SHALL implement the per-operand priority match over DEPTH entries and be instantiated NUM_SRC times.

Verification
REQ-036 Issue add r3 (regwrite), then next cycle issue src r3,r0 -> fwd_sel op0=1, op1=0, stall=0.
REQ-037 Issue lw r5, then next cycle issue src r5 -> stall=1 for one cycle; retried cycle fwd_sel op0=2, stall=0; stall_count=1.
REQ-038 Issue r4 writers in two consecutive cycles, then consumer of r4 -> fwd_sel=1 (youngest), not 2.
REQ-039 Issue lw r7, then next cycle issue consumer of r7 with flush=1 -> stall=0; following cycle stage 2 invalid, consumer of r7 sees fwd_sel=0.
REQ-040 Write r0 then consume r0 -> fwd_sel=0; force 2^CNT_W+5 load-use stalls -> stall_count=all-ones.
REQ-041 Pulse rst with lw r2 in stage 1 -> next cycle consumer of r2 sees stall=0, fwd_sel=0, stall_count=0.

Source files
------------

// File: rtl/forward_scoreboard_pkg.sv
// Shared types and helpers for the forwarding scoreboard: stage-entry layout,
// forward-select encoding and select-width computation.
package forward_scoreboard_pkg;

    // Widest register address an entry can hold; narrower addresses are zero-extended.
    localparam int unsigned MAX_REG_W = 8;

    // Forward-select value meaning "read the register file".
    localparam int unsigned SEL_RF = 0;

    typedef struct packed {
        logic                 valid;
        logic                 regwrite;
        logic                 is_load;
        logic [MAX_REG_W-1:0] rd;
    } stage_entry_t;

    localparam stage_entry_t BUBBLE = '0;

    // Select width for DEPTH stages plus the register-file code.
    function automatic int unsigned sel_width(input int unsigned depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fwd_match.sv
// Priority match of one source operand against all in-flight stages.
// The youngest (lowest-numbered) matching producer wins.
module fwd_match
    import forward_scoreboard_pkg::*;
#(
    parameter int unsigned DEPTH      = 3,
    parameter int unsigned LOAD_READY = 2,
    parameter int unsigned SEL_W      = 2
) (
    input  stage_entry_t [DEPTH:1] stages,
    input  logic [MAX_REG_W-1:0]   src,
    output logic [SEL_W-1:0]       sel,
    output logic                   load_hazard
);

    // Scan oldest to youngest so the last hit (youngest) sticks.
    always_comb begin
        sel         = SEL_W'(SEL_RF);
        load_hazard = 1'b0;
        for (int k = int'(DEPTH); k >= 1; k--) begin
            if (stages[k].valid && stages[k].regwrite &&
                stages[k].rd != '0 && stages[k].rd == src) begin
                sel         = SEL_W'(k);
                load_hazard = stages[k].is_load && (k < int'(LOAD_READY));
            end
        end
    end

endmodule

// File: rtl/forward_scoreboard.sv
// Forwarding scoreboard: tracks in-flight destination registers, selects the
// forwarding source for each operand of the issuing instruction, and stalls
// on load-use hazards whose load result is not yet forwardable.
module forward_scoreboard
    import forward_scoreboard_pkg::*;
#(
    parameter int unsigned REG_W      = 5,
    parameter int unsigned NUM_SRC    = 2,
    parameter int unsigned DEPTH      = 3,
    parameter int unsigned LOAD_READY = 2,
    parameter int unsigned CNT_W      = 16,
    localparam int unsigned SEL_W     = sel_width(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     issue_valid,
    input  logic                     issue_regwrite,
    input  logic                     issue_is_load,
    input  logic [REG_W-1:0]         issue_rd,
    input  logic [NUM_SRC*REG_W-1:0] src_addr,
    input  logic                     flush,
    output logic [NUM_SRC*SEL_W-1:0] fwd_sel,
    output logic                     stall,
    output logic [CNT_W-1:0]         stall_count
);

    // REG_W must not exceed MAX_REG_W; addresses are zero-extended into entries.
    stage_entry_t [DEPTH:1] stage_q;
    stage_entry_t [DEPTH:1] stage_d;
    logic [NUM_SRC-1:0]     hazard;
    logic [MAX_REG_W-1:0]   src_ext [NUM_SRC];

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        assign src_ext[i] = MAX_REG_W'(src_addr[i*REG_W +: REG_W]);

        fwd_match #(
            .DEPTH      (DEPTH),
            .LOAD_READY (LOAD_READY),
            .SEL_W      (SEL_W)
        ) u_match (
            .stages      (stage_q),
            .src         (src_ext[i]),
            .sel         (fwd_sel[i*SEL_W +: SEL_W]),
            .load_hazard (hazard[i])
        );
    end

    // Flush overrides any hazard so a killed issue never stalls.
    assign stall = issue_valid && !flush && (|hazard);

    // Advance the pipeline image; capture issue only when it actually proceeds.
    always_comb begin
        stage_d    = '0;
        stage_d[1] = BUBBLE;
        if (issue_valid && !stall && !flush) begin
            stage_d[1].valid    = 1'b1;
            stage_d[1].regwrite = issue_regwrite;
            stage_d[1].is_load  = issue_is_load;
            stage_d[1].rd       = MAX_REG_W'(issue_rd);
        end
        for (int k = 2; k <= int'(DEPTH); k++) begin
            // Flush kills the instruction leaving stage 1.
            stage_d[k] = (k == 2 && flush) ? BUBBLE : stage_q[k-1];
        end
    end

    // Stage registers and saturating stall counter with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q     <= '0;
            stall_count <= '0;
        end else begin
            stage_q <= stage_d;
            if (stall && stall_count != '1) begin
                stall_count <= stall_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_forward_scoreboard.sv
// Self-checking bench for forward_scoreboard: directed vectors with literal
// expectations plus a per-cycle comparison against a history-based model.
module tb_forward_scoreboard;

    localparam int unsigned REG_W      = 5;
    localparam int unsigned NUM_SRC    = 2;
    localparam int unsigned DEPTH      = 3;
    localparam int unsigned LOAD_READY = 2;
    localparam int unsigned CNT_W      = 6;
    localparam int unsigned SEL_W      = 2;
    localparam int          CNT_MAX    = (1 << CNT_W) - 1;

    logic                     clk;
    logic                     rst;
    logic                     issue_valid;
    logic                     issue_regwrite;
    logic                     issue_is_load;
    logic [REG_W-1:0]         issue_rd;
    logic [NUM_SRC*REG_W-1:0] src_addr;
    logic                     flush;
    logic [NUM_SRC*SEL_W-1:0] fwd_sel;
    logic                     stall;
    logic [CNT_W-1:0]         stall_count;

    forward_scoreboard #(
        .REG_W      (REG_W),
        .NUM_SRC    (NUM_SRC),
        .DEPTH      (DEPTH),
        .LOAD_READY (LOAD_READY),
        .CNT_W      (CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .issue_valid    (issue_valid),
        .issue_regwrite (issue_regwrite),
        .issue_is_load  (issue_is_load),
        .issue_rd       (issue_rd),
        .src_addr       (src_addr),
        .flush          (flush),
        .fwd_sel        (fwd_sel),
        .stall          (stall),
        .stall_count    (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit model_on = 0;

    // Model: list of instructions issued in past cycles, youngest first.
    typedef struct {
        bit v;
        bit wr;
        bit ld;
        int rd;
    } rec_t;

    rec_t hist[$];
    int   m_cnt;

    task automatic check(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int src_of(input int i);
        return int'(src_addr[i*REG_W +: REG_W]);
    endfunction

    // Expected select: position of the youngest live writer of src.
    function automatic int m_sel(input int src);
        for (int k = 0; k < hist.size(); k++) begin
            if (hist[k].v && hist[k].wr && hist[k].rd != 0 && hist[k].rd == src) return k + 1;
        end
        return 0;
    endfunction

    function automatic bit m_stall();
        int s;
        if (!issue_valid || flush) return 0;
        for (int i = 0; i < NUM_SRC; i++) begin
            s = m_sel(src_of(i));
            if (s != 0 && s < LOAD_READY && hist[s-1].ld) return 1;
        end
        return 0;
    endfunction

    // Model state update at each rising edge.
    always @(posedge clk) begin
        rec_t n;
        bit   st;
        if (rst) begin
            hist.delete();
            for (int k = 0; k < DEPTH; k++) hist.push_back('{v: 0, wr: 0, ld: 0, rd: 0});
            m_cnt    = 0;
            model_on = 1;
        end else if (model_on) begin
            st = m_stall();
            if (st && m_cnt < CNT_MAX) m_cnt++;
            n.v  = issue_valid && !st && !flush;
            n.wr = issue_regwrite;
            n.ld = issue_is_load;
            n.rd = int'(issue_rd);
            if (flush) hist[0].v = 0;
            hist.push_front(n);
            while (hist.size() > DEPTH) void'(hist.pop_back());
        end
    end

    // Per-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        if (model_on) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                check($sformatf("model_fwd_sel_op%0d", i),
                      int'(fwd_sel[i*SEL_W +: SEL_W]), m_sel(src_of(i)));
            end
            check("model_stall", int'(stall), int'(m_stall()));
            check("model_stall_count", int'(stall_count), m_cnt);
        end
    end

    // One cycle of stimulus with optional literal expectations (-1 = skip).
    task automatic step(input string nm, input bit v, input bit wr, input bit ld, input int rd,
                        input int s0, input int s1, input bit fl, input bit r,
                        input int e0, input int e1, input int est, input int ecnt);
        issue_valid    = v;
        issue_regwrite = wr;
        issue_is_load  = ld;
        issue_rd       = REG_W'(rd);
        src_addr[0 +: REG_W]     = REG_W'(s0);
        src_addr[REG_W +: REG_W] = REG_W'(s1);
        flush = fl;
        rst   = r;
        @(negedge clk);
        if (e0 >= 0) check({nm, "_sel0"}, int'(fwd_sel[0 +: SEL_W]), e0);
        if (e1 >= 0) check({nm, "_sel1"}, int'(fwd_sel[SEL_W +: SEL_W]), e1);
        if (est >= 0) check({nm, "_stall"}, int'(stall), est);
        if (ecnt >= 0) check({nm, "_count"}, int'(stall_count), ecnt);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step("idle", 0, 0, 0, 0, 0, 0, 0, 0, -1, -1, 0, -1);
    endtask

    initial begin
        rst = 1'b1;
        issue_valid = 1'b0;
        issue_regwrite = 1'b0;
        issue_is_load = 1'b0;
        issue_rd = '0;
        src_addr = '0;
        flush = 1'b0;
        @(posedge clk);
        #1;

        // Right after reset: everything zero even with a hazard-shaped issue.
        step("reset_any", 1, 1, 1, 3, 3, 3, 0, 1, 0, 0, 0, 0);
        step("after_reset", 1, 0, 0, 0, 3, 3, 0, 0, 0, 0, 0, 0);
        idle(3);

        // ALU producer then consumer: forward from stage 1.
        step("add_r3", 1, 1, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0);
        step("use_r3", 1, 0, 0, 0, 3, 0, 0, 0, 1, 0, 0, 0);
        idle(3);

        // Load-use: one stall cycle, then forward from stage 2; same-address operands agree.
        step("lw_r5", 1, 1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0);
        step("use_r5_stall", 1, 0, 0, 0, 5, 5, 0, 0, 1, 1, 1, 0);
        step("use_r5_retry", 1, 0, 0, 0, 5, 5, 0, 0, 2, 2, 0, 1);
        idle(3);

        // Two writers of r4: youngest wins.
        step("wr_r4_a", 1, 1, 0, 4, 0, 0, 0, 0, 0, 0, 0, 1);
        step("wr_r4_b", 1, 1, 0, 4, 0, 0, 0, 0, 0, 0, 0, 1);
        step("use_r4", 1, 0, 0, 0, 4, 0, 0, 0, 1, 0, 0, 1);
        idle(3);

        // Flush beats stall and kills the load on its way to stage 2.
        step("lw_r7", 1, 1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 1);
        step("use_r7_flush", 1, 0, 0, 0, 7, 0, 1, 0, 1, 0, 0, 1);
        step("use_r7_after", 1, 0, 0, 0, 7, 0, 0, 0, 0, 0, 0, 1);
        idle(3);

        // r0 is never forwarded.
        step("wr_r0", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step("use_r0", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(3);

        // Drive 2^CNT_W+5 load-use stalls; the counter must stick at all-ones.
        for (int i = 0; i < CNT_MAX + 6; i++) begin
            step("sat_lw", 1, 1, 1, 1, 0, 0, 0, 0, -1, -1, 0, -1);
            step("sat_use", 1, 0, 0, 0, 1, 0, 0, 0, 1, -1, 1, -1);
        end
        step("sat_done", 0, 0, 0, 0, 0, 0, 0, 0, -1, -1, 0, CNT_MAX);

        // Reset with a load in stage 1 wins over flush and issue; no residual stall.
        step("lw_r2", 1, 1, 1, 2, 0, 0, 0, 0, 0, 0, 0, CNT_MAX);
        step("rst_pulse", 1, 1, 1, 2, 2, 0, 1, 1, 1, 0, 0, CNT_MAX);
        step("use_r2", 1, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0);
        step("use_r2_again", 1, 0, 0, 0, 2, 2, 0, 0, 0, 0, 0, 0);
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
